fuq_issue_queue: RTL and testbench
==================================

# fuq_issue_queue

Parametrised, depth-configurable issue queue for one functional unit. It buffers renamed instructions and tracks per-operand readiness, waking operands from PRN broadcasts on every FU channel, including this FU's own output. Each cycle it selects the oldest fully-ready entry into a registered issue slot that drives the PRF read ports and the FU handshake. It sits between the instruction router and one FU and replaces the fixed single-FU queue in each `*_fuq_wrap`.

## Interface
- `INST_ID_BITS`, 6, instruction ID width
- `PRN_BITS`, 6, physical register number width
- `MAX_OPERANDS`, 3, source and destination operand slots per instruction
- `FU_COUNT`, 4, wakeup broadcast channels, including this FU's own channel
- `QUEUE_DEPTH`, 8, number of entries (≥2)

- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `inst_valid`  in  1  router offers an instruction
- `queue_ready`  out  1  queue accepts an instruction this cycle
- `inst_id`  in  INST_ID_BITS  instruction ID
- `raw_instr`  in  32  encoding
- `instr_pc`  in  64  PC
- `prn_input_valid[MAX_OPERANDS]`  in  1 each  source slot used
- `prn_input_ready[MAX_OPERANDS]`  in  1 each  source already ready at dispatch
- `prn_input[MAX_OPERANDS]`  in  PRN_BITS each  source tags
- `prn_output_valid[MAX_OPERANDS]`  in  1 each  destination slot used
- `prn_output[MAX_OPERANDS]`  in  PRN_BITS each  destination tags
- `set_prn_ready[FU_COUNT][MAX_OPERANDS]`  in  1 each  wakeup strobes
- `set_prn[FU_COUNT][MAX_OPERANDS]`  in  PRN_BITS each  wakeup tags
- `issue_valid`  out  1  issue slot holds an instruction
- `issue_ready`  in  1  FU accepts the slot
- `issue_inst_id`, `issue_raw_instr`, `issue_pc`  out  INST_ID_BITS/32/64  issued instruction
- `issue_prn_output_valid[MAX_OPERANDS]`, `issue_prn_output[MAX_OPERANDS]`  out  1/PRN_BITS each  destinations
- `prf_read_enable[MAX_OPERANDS]`  out  1 each  read this source
- `prf_read_prn[MAX_OPERANDS]`  out  PRN_BITS each  source tag to read
- `occupancy`  out  $clog2(QUEUE_DEPTH+1)  valid entries, excluding the issue slot

## Operation
- **Storage:** compacting array. Entry 0 is the oldest. Valid entries are contiguous from index 0.
- **Accept:** an instruction is accepted when `inst_valid && queue_ready`.
  - It is written at index `occupancy`, or at `occupancy-1` if an entry leaves the queue in the same cycle.
  - Each source slot's ready bit is set when any of these holds: the slot is unused, `prn_input_ready` is high, or a same-cycle wakeup matches the tag.
- **Wakeup:** for every valid, not-ready operand, the ready bit is set if any channel c, slot k has `set_prn_ready[c][k]` high and `set_prn[c][k]` equal to the operand tag. Ready bits never clear.
- **Select:** picks the lowest-index entry whose used sources are all ready.
- **Move to issue slot:** the selected entry moves when the slot is empty or is being consumed this cycle (`issue_valid && issue_ready`).
  - The moved entry is removed and entries above it shift down by one.
- **Issue slot:** holds its contents until consumed.
  - `prf_read_enable[k]` = `issue_valid && slot k used`.
  - `prf_read_prn[k]` = source tag k.
- `queue_ready` = `occupancy < QUEUE_DEPTH` (combinational from the count register). There is no accept-when-full-with-departure path.
- **Count update:** `occupancy` is incremented by accept and decremented by the move into the issue slot; both may happen in the same cycle. It never exceeds QUEUE_DEPTH.

## Timing
- **Reset:** all entries invalid, `occupancy`=0, `issue_valid`=0, all issue/PRF outputs 0, `queue_ready`=1. Reset mid-operation discards all contents immediately.
- **Latency:** an instruction accepted fully ready at edge N is in the issue slot after edge N+1, so `issue_valid` is high in cycle N+1. This is the minimum dispatch-to-issue latency of 2 edges.
- **Wakeup-to-issue:** a wakeup in cycle M makes the entry selectable in cycle M+1; it is in the issue slot after edge M+1.
- **Back-to-back issue:** with `issue_ready` held high, one instruction issues per cycle.
- **Stalled FU:** with `issue_ready` low, the slot and all its outputs hold stable and no entry leaves the queue.

## Configuration
- **`FUQ_FLUSH_EN` defined:** adds input `flush` (1 bit).
  - At the next edge it invalidates all entries and the issue slot and sets `occupancy`=0.
  - `queue_ready` is 0 during a flush cycle, and any offered instruction is not accepted.
  - Flush takes priority over accept, wakeup and move.
- **`FUQ_FLUSH_EN` undefined:** the port is absent and entries leave only by issue.

## Test plan
- Reset, then accept id=5 with all sources ready, `issue_ready`=1 -> `issue_valid` high with id 5 one cycle after acceptance, `prf_read_enable` set for used slots only.
- Accept id=1 waiting on PRN 12, then id=2 ready -> id 2 issues first. Drive `set_prn[3][0]`=12 strobe -> id 1 issues the following cycle.
- Accept id=7 waiting on PRN 9 while channel 0 broadcasts PRN 9 in the same cycle -> id 7 issues with no further wakeup.
- Fill 8 entries with `issue_ready`=0 -> `queue_ready`=0 and `occupancy`=8. Raise `issue_ready` -> one issue per cycle, in age order.
- Accept and issue in the same cycle at `occupancy`=3 -> `occupancy` stays 3 and the new entry lands at index 2.
- With `FUQ_FLUSH_EN`, assert `flush` with 4 entries and `issue_valid`=1 -> next cycle `occupancy`=0, `issue_valid`=0, and the same-cycle instruction is dropped.

Source files
------------

// File: rtl/fuq_issue_queue.sv
// Issue queue for one FU: age-ordered compacting entries, PRN wakeup, oldest-ready select; `FUQ_FLUSH_EN adds a flush input.
// Latency: fully-ready dispatch at edge N is in the issue slot after edge N+1; a wakeup in cycle M issues after edge M+1.
// Backpressure: queue_ready drops when full or flushing; issue_ready low freezes the issue slot and all departures.
module fuq_issue_queue #(
   parameter int INST_ID_BITS = 6,
   parameter int PRN_BITS     = 6,
   parameter int MAX_OPERANDS = 3,
   parameter int FU_COUNT     = 4,
   parameter int QUEUE_DEPTH  = 8
) (
   input  logic                             clk,
   input  logic                             rst,
`ifdef FUQ_FLUSH_EN
   input  logic                             flush,
`endif
   input  logic                             inst_valid,
   output logic                             queue_ready,
   input  logic [INST_ID_BITS-1:0]          inst_id,
   input  logic [31:0]                      raw_instr,
   input  logic [63:0]                      instr_pc,
   input  logic                             prn_input_valid [MAX_OPERANDS],
   input  logic                             prn_input_ready [MAX_OPERANDS],
   input  logic [PRN_BITS-1:0]              prn_input [MAX_OPERANDS],
   input  logic                             prn_output_valid [MAX_OPERANDS],
   input  logic [PRN_BITS-1:0]              prn_output [MAX_OPERANDS],
   input  logic                             set_prn_ready [FU_COUNT][MAX_OPERANDS],
   input  logic [PRN_BITS-1:0]              set_prn [FU_COUNT][MAX_OPERANDS],
   output logic                             issue_valid,
   input  logic                             issue_ready,
   output logic [INST_ID_BITS-1:0]          issue_inst_id,
   output logic [31:0]                      issue_raw_instr,
   output logic [63:0]                      issue_pc,
   output logic                             issue_prn_output_valid [MAX_OPERANDS],
   output logic [PRN_BITS-1:0]              issue_prn_output [MAX_OPERANDS],
   output logic                             prf_read_enable [MAX_OPERANDS],
   output logic [PRN_BITS-1:0]              prf_read_prn [MAX_OPERANDS],
   output logic [$clog2(QUEUE_DEPTH+1)-1:0] occupancy
);

   localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
   localparam int IDX_W = $clog2(QUEUE_DEPTH);

   typedef struct packed {
      logic [INST_ID_BITS-1:0]               inst_id;
      logic [31:0]                           raw_instr;
      logic [63:0]                           pc;
      logic [MAX_OPERANDS-1:0]               src_vld;
      logic [MAX_OPERANDS-1:0]               src_rdy;
      logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] src_prn;
      logic [MAX_OPERANDS-1:0]               dst_vld;
      logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] dst_prn;
   } entry_t;

   entry_t           ent     [QUEUE_DEPTH];
   entry_t           ent_nxt [QUEUE_DEPTH];
   entry_t           ent_ext [QUEUE_DEPTH+1];
   entry_t           new_ent;
   entry_t           iss;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] wr_idx;
   logic [IDX_W-1:0] sel_idx;
   logic             sel_found;
   logic             move;
   logic             accept;
   logic             do_flush;

`ifdef FUQ_FLUSH_EN
   assign do_flush = flush;
`else
   assign do_flush = 1'b0;
`endif

   function automatic logic wake_hit(input logic [PRN_BITS-1:0] tag);
      logic hit;
      hit = 1'b0;
      for (int c = 0; c < FU_COUNT; c++)
         for (int k = 0; k < MAX_OPERANDS; k++)
            if (set_prn_ready[c][k] && set_prn[c][k] == tag) hit = 1'b1;
      return hit;
   endfunction

   // Selection looks only at registered ready bits, so a wakeup costs one cycle before select.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = QUEUE_DEPTH - 1; i >= 0; i--) begin
         if (CNT_W'(i) < count && &ent[i].src_rdy) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
         end
      end
   end

   assign queue_ready = (count < CNT_W'(QUEUE_DEPTH)) && !do_flush;
   assign move        = sel_found && (!issue_valid || issue_ready);
   assign accept      = inst_valid && queue_ready;
   assign wr_idx      = count - CNT_W'(move);

   always_comb begin
      new_ent           = '0;
      new_ent.inst_id   = inst_id;
      new_ent.raw_instr = raw_instr;
      new_ent.pc        = instr_pc;
      for (int k = 0; k < MAX_OPERANDS; k++) begin
         new_ent.src_vld[k] = prn_input_valid[k];
         new_ent.src_rdy[k] = !prn_input_valid[k] || prn_input_ready[k] || wake_hit(prn_input[k]);
         new_ent.src_prn[k] = prn_input[k];
         new_ent.dst_vld[k] = prn_output_valid[k];
         new_ent.dst_prn[k] = prn_output[k];
      end
   end

   always_comb begin
      for (int i = 0; i < QUEUE_DEPTH; i++) ent_ext[i] = ent[i];
      ent_ext[QUEUE_DEPTH] = '0;
   end

   // Compact over the departing entry, apply wakeups, then append the new arrival.
   always_comb begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
         ent_nxt[i] = (move && IDX_W'(i) >= sel_idx) ? ent_ext[i+1] : ent[i];
         for (int k = 0; k < MAX_OPERANDS; k++)
            if (wake_hit(ent_nxt[i].src_prn[k])) ent_nxt[i].src_rdy[k] = 1'b1;
      end
      if (accept) ent_nxt[IDX_W'(wr_idx)] = new_ent;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count       <= '0;
         issue_valid <= 1'b0;
         iss         <= '0;
         for (int i = 0; i < QUEUE_DEPTH; i++) ent[i] <= '0;
      end else if (do_flush) begin
         count       <= '0;
         issue_valid <= 1'b0;
      end else begin
         count <= count + CNT_W'(accept) - CNT_W'(move);
         for (int i = 0; i < QUEUE_DEPTH; i++) ent[i] <= ent_nxt[i];
         if (move) begin
            issue_valid <= 1'b1;
            iss         <= ent[sel_idx];
         end else if (issue_ready) begin
            issue_valid <= 1'b0;
         end
      end
   end

   assign issue_inst_id   = iss.inst_id;
   assign issue_raw_instr = iss.raw_instr;
   assign issue_pc        = iss.pc;
   assign occupancy       = count;

   always_comb begin
      for (int k = 0; k < MAX_OPERANDS; k++) begin
         issue_prn_output_valid[k] = iss.dst_vld[k];
         issue_prn_output[k]       = iss.dst_prn[k];
         prf_read_enable[k]        = issue_valid && iss.src_vld[k];
         prf_read_prn[k]           = iss.src_prn[k];
      end
   end

endmodule

// File: tb/tb_fuq_issue_queue.sv
// Directed bench for fuq_issue_queue: vector table for dispatch/wakeup/issue, hand sequences for fill, drain, same-cycle accept+issue, flush and reset.
module tb_fuq_issue_queue;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        inst_valid, queue_ready, issue_valid, issue_ready;
   logic [5:0]  inst_id, issue_inst_id;
   logic [31:0] raw_instr, issue_raw_instr;
   logic [63:0] instr_pc, issue_pc;
   logic        prn_input_valid [3];
   logic        prn_input_ready [3];
   logic [5:0]  prn_input [3];
   logic        prn_output_valid [3];
   logic [5:0]  prn_output [3];
   logic        set_prn_ready [4][3];
   logic [5:0]  set_prn [4][3];
   logic        issue_prn_output_valid [3];
   logic [5:0]  issue_prn_output [3];
   logic        prf_read_enable [3];
   logic [5:0]  prf_read_prn [3];
   logic [3:0]  occupancy;
`ifdef FUQ_FLUSH_EN
   logic        flush;
`endif

   fuq_issue_queue dut (
      .clk(clk), .rst(rst),
`ifdef FUQ_FLUSH_EN
      .flush(flush),
`endif
      .inst_valid(inst_valid), .queue_ready(queue_ready), .inst_id(inst_id),
      .raw_instr(raw_instr), .instr_pc(instr_pc),
      .prn_input_valid(prn_input_valid), .prn_input_ready(prn_input_ready), .prn_input(prn_input),
      .prn_output_valid(prn_output_valid), .prn_output(prn_output),
      .set_prn_ready(set_prn_ready), .set_prn(set_prn),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_inst_id(issue_inst_id),
      .issue_raw_instr(issue_raw_instr), .issue_pc(issue_pc),
      .issue_prn_output_valid(issue_prn_output_valid), .issue_prn_output(issue_prn_output),
      .prf_read_enable(prf_read_enable), .prf_read_prn(prf_read_prn),
      .occupancy(occupancy)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      inst_valid  = 1'b0;
      inst_id     = '0;
      raw_instr   = '0;
      instr_pc    = '0;
      issue_ready = 1'b0;
`ifdef FUQ_FLUSH_EN
      flush       = 1'b0;
`endif
      for (int k = 0; k < 3; k++) begin
         prn_input_valid[k]  = 1'b0;
         prn_input_ready[k]  = 1'b0;
         prn_input[k]        = '0;
         prn_output_valid[k] = 1'b0;
         prn_output[k]       = '0;
      end
      for (int c = 0; c < 4; c++)
         for (int k = 0; k < 3; k++) begin
            set_prn_ready[c][k] = 1'b0;
            set_prn[c][k]       = '0;
         end
   endtask

   task automatic drive_inst(input logic [5:0] id, input logic [2:0] sv, input logic [2:0] sr,
                             input logic [5:0] tag0);
      inst_valid = 1'b1;
      inst_id    = id;
      raw_instr  = 32'hA000_0000 | 32'(id);
      instr_pc   = 64'h1000 + 64'(id) * 4;
      for (int k = 0; k < 3; k++) begin
         prn_input_valid[k] = sv[k];
         prn_input_ready[k] = sr[k];
         prn_input[k]       = (k == 0) ? tag0 : 6'(40 + k);
      end
      prn_output_valid[0] = 1'b1;
      prn_output[0]       = id ^ 6'h20;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] pre_bits();
      return {prf_read_enable[2], prf_read_enable[1], prf_read_enable[0]};
   endfunction

   typedef struct {
      bit       iv;
      bit [5:0] id;
      bit [2:0] sv;
      bit [2:0] sr;
      bit [5:0] tag0;
      bit       wv;
      int       wc;
      int       wk;
      bit [5:0] wt;
      bit       ir;
      bit       exp_iv;
      bit [5:0] exp_id;
      int       exp_occ;
      bit       exp_qr;
      bit [2:0] exp_pre;
      bit [5:0] exp_prn0;
   } vec_t;

   function automatic vec_t mk(bit iv, bit [5:0] id, bit [2:0] sv, bit [2:0] sr, bit [5:0] tag0,
                               bit wv, int wc, int wk, bit [5:0] wt, bit ir,
                               bit exp_iv, bit [5:0] exp_id, int exp_occ, bit exp_qr,
                               bit [2:0] exp_pre, bit [5:0] exp_prn0);
      vec_t v;
      v.iv = iv; v.id = id; v.sv = sv; v.sr = sr; v.tag0 = tag0;
      v.wv = wv; v.wc = wc; v.wk = wk; v.wt = wt; v.ir = ir;
      v.exp_iv = exp_iv; v.exp_id = exp_id; v.exp_occ = exp_occ; v.exp_qr = exp_qr;
      v.exp_pre = exp_pre; v.exp_prn0 = exp_prn0;
      return v;
   endfunction

   localparam int NV = 17;
   vec_t tv [NV];

   initial begin
      //             iv id  sv      sr      tag0 wv wc wk wt  ir  eiv eid occ qr pre     prn0
      tv[0]  = mk(1, 5,  3'b011, 3'b011, 3,   0, 0, 0, 0,  1,  0,  0,  1,  1, 3'b000, 0);
      tv[1]  = mk(0, 0,  3'b000, 3'b000, 0,   0, 0, 0, 0,  1,  1,  5,  0,  1, 3'b011, 3);
      tv[2]  = mk(1, 1,  3'b001, 3'b000, 12,  0, 0, 0, 0,  1,  0,  0,  1,  1, 3'b000, 0);
      tv[3]  = mk(1, 2,  3'b001, 3'b001, 30,  0, 0, 0, 0,  1,  0,  0,  2,  1, 3'b000, 0);
      tv[4]  = mk(0, 0,  3'b000, 3'b000, 0,   0, 0, 0, 0,  1,  1,  2,  1,  1, 3'b001, 30);
      tv[5]  = mk(0, 0,  3'b000, 3'b000, 0,   1, 3, 0, 12, 1,  0,  0,  1,  1, 3'b000, 0);
      tv[6]  = mk(0, 0,  3'b000, 3'b000, 0,   0, 0, 0, 0,  1,  1,  1,  0,  1, 3'b001, 12);
      tv[7]  = mk(1, 7,  3'b001, 3'b000, 9,   1, 0, 0, 9,  1,  0,  0,  1,  1, 3'b000, 0);
      tv[8]  = mk(0, 0,  3'b000, 3'b000, 0,   0, 0, 0, 0,  1,  1,  7,  0,  1, 3'b001, 9);
      tv[9]  = mk(0, 0,  3'b000, 3'b000, 0,   0, 0, 0, 0,  1,  0,  0,  0,  1, 3'b000, 0);
      tv[10] = mk(1, 3,  3'b001, 3'b000, 15,  0, 0, 0, 0,  1,  0,  0,  1,  1, 3'b000, 0);
      tv[11] = mk(0, 0,  3'b000, 3'b000, 0,   1, 1, 2, 14, 1,  0,  0,  1,  1, 3'b000, 0);
      tv[12] = mk(0, 0,  3'b000, 3'b000, 0,   0, 0, 0, 0,  1,  0,  0,  1,  1, 3'b000, 0);
      tv[13] = mk(0, 0,  3'b000, 3'b000, 0,   1, 2, 1, 15, 1,  0,  0,  1,  1, 3'b000, 0);
      tv[14] = mk(0, 0,  3'b000, 3'b000, 0,   0, 0, 0, 0,  1,  1,  3,  0,  1, 3'b001, 15);
      tv[15] = mk(0, 0,  3'b000, 3'b000, 0,   0, 0, 0, 0,  0,  1,  3,  0,  1, 3'b001, 15);
      tv[16] = mk(0, 0,  3'b000, 3'b000, 0,   0, 0, 0, 0,  1,  0,  0,  0,  1, 3'b000, 0);

      rst = 1'b1;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("reset occupancy", occupancy, 0);
      check("reset queue_ready", queue_ready, 1);
      check("reset issue_valid", issue_valid, 0);
      check("reset prf_read_enable", pre_bits(), 0);
      check("reset issue_inst_id", issue_inst_id, 0);
      check("reset issue_pc", issue_pc, 0);

      for (int i = 0; i < NV; i++) begin
         clear_inputs();
         issue_ready = tv[i].ir;
         if (tv[i].iv) drive_inst(tv[i].id, tv[i].sv, tv[i].sr, tv[i].tag0);
         if (tv[i].wv) begin
            set_prn_ready[tv[i].wc][tv[i].wk] = 1'b1;
            set_prn[tv[i].wc][tv[i].wk]       = tv[i].wt;
         end
         step();
         check($sformatf("v%0d occupancy", i), occupancy, tv[i].exp_occ);
         check($sformatf("v%0d queue_ready", i), queue_ready, tv[i].exp_qr);
         check($sformatf("v%0d issue_valid", i), issue_valid, tv[i].exp_iv);
         check($sformatf("v%0d prf_read_enable", i), pre_bits(), tv[i].exp_pre);
         if (tv[i].exp_iv) begin
            check($sformatf("v%0d issue_inst_id", i), issue_inst_id, tv[i].exp_id);
            check($sformatf("v%0d prf_read_prn0", i), prf_read_prn[0], tv[i].exp_prn0);
            check($sformatf("v%0d issue_prn_output0", i), issue_prn_output[0], tv[i].exp_id ^ 6'h20);
            check($sformatf("v%0d issue_raw_instr", i), issue_raw_instr, 32'hA000_0000 | 32'(tv[i].exp_id));
            check($sformatf("v%0d issue_pc", i), issue_pc, 64'h1000 + 64'(tv[i].exp_id) * 4);
         end
      end

      // Fill with a stalled FU: the first instruction occupies the slot, eight more fill the array.
      for (int n = 0; n < 9; n++) begin
         clear_inputs();
         drive_inst(6'(10 + n), 3'b001, 3'b001, 6'(n + 1));
         step();
         check($sformatf("fill%0d occupancy", n), occupancy, (n < 2) ? 1 : n);
         if (n > 0) check($sformatf("fill%0d stalled id", n), issue_inst_id, 10);
      end
      check("full queue_ready", queue_ready, 0);
      clear_inputs();
      drive_inst(6'd19, 3'b001, 3'b001, 6'd1);
      step();
      check("full refuse occupancy", occupancy, 8);
      check("full stalled issue id", issue_inst_id, 10);
      clear_inputs();
      issue_ready = 1'b1;
      for (int n = 0; n < 8; n++) begin
         step();
         check($sformatf("drain%0d issue_valid", n), issue_valid, 1);
         check($sformatf("drain%0d issue id", n), issue_inst_id, 11 + n);
         check($sformatf("drain%0d occupancy", n), occupancy, 7 - n);
      end
      step();
      check("drain empty issue_valid", issue_valid, 0);

      // Same-cycle accept and issue at occupancy 3.
      for (int n = 0; n < 4; n++) begin
         clear_inputs();
         drive_inst(6'(20 + n), 3'b001, 3'b001, 6'd2);
         step();
      end
      check("pre-swap occupancy", occupancy, 3);
      check("pre-swap issue id", issue_inst_id, 20);
      clear_inputs();
      drive_inst(6'd24, 3'b001, 3'b001, 6'd2);
      issue_ready = 1'b1;
      step();
      check("swap occupancy", occupancy, 3);
      check("swap issue id", issue_inst_id, 21);
      clear_inputs();
      issue_ready = 1'b1;
      for (int n = 0; n < 3; n++) begin
         step();
         check($sformatf("swap drain%0d id", n), issue_inst_id, 22 + n);
         check($sformatf("swap drain%0d occupancy", n), occupancy, 2 - n);
      end
      step();
      check("swap drain empty", issue_valid, 0);

`ifdef FUQ_FLUSH_EN
      for (int n = 0; n < 5; n++) begin
         clear_inputs();
         drive_inst(6'(30 + n), 3'b001, 3'b001, 6'd3);
         step();
      end
      check("pre-flush occupancy", occupancy, 4);
      check("pre-flush issue_valid", issue_valid, 1);
      clear_inputs();
      drive_inst(6'd35, 3'b001, 3'b001, 6'd3);
      flush = 1'b1;
      #1;
      check("flush queue_ready", queue_ready, 0);
      step();
      check("flush occupancy", occupancy, 0);
      check("flush issue_valid", issue_valid, 0);
      clear_inputs();
      issue_ready = 1'b1;
      step();
      check("post-flush occupancy", occupancy, 0);
      check("post-flush issue_valid", issue_valid, 0);
`endif

      // Asynchronous reset with contents in flight.
      for (int n = 0; n < 3; n++) begin
         clear_inputs();
         drive_inst(6'(40 + n), 3'b011, 3'b011, 6'd4);
         step();
      end
      check("pre-reset occupancy", occupancy, 2);
      clear_inputs();
      rst = 1'b1;
      #1;
      check("mid reset occupancy", occupancy, 0);
      check("mid reset issue_valid", issue_valid, 0);
      check("mid reset prf_read_enable", pre_bits(), 0);
      check("mid reset queue_ready", queue_ready, 1);
      #1 rst = 1'b0;
      issue_ready = 1'b1;
      step();
      check("after reset issue_valid", issue_valid, 0);
      check("after reset occupancy", occupancy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
